// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-serial program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } loader_state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Collects payload bytes little-endian into 32-bit instruction words.
// Latency: word_vld/word_dat are combinational on the byte that completes a word.
// Backpressure: none; consumes a byte whenever shift is high.
//
// Ports: clock/reset, shift (byte accepted in payload phase), byte_dat,
//        word_dat (assembled word incl. current byte), word_vld (4th byte now).
module word_assembler
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        shift,
    input  logic [7:0]  byte_dat,
    output logic [31:0] word_dat,
    output logic        word_vld
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

    logic [CNT_W-1:0] byte_cnt;
    // Earlier bytes of the current word; newest byte enters at the top so the
    // first byte received ends up in bits [7:0].
    logic [23:0]      partial;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
            partial  <= '0;
        end else if (shift) begin
            byte_cnt <= byte_cnt + 1'b1;
            partial  <= {byte_dat, partial[23:8]};
        end
    end

    assign word_dat = {byte_dat, partial};
    assign word_vld = shift && (byte_cnt == LAST_BYTE);

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses [len16][payload][xor csum] and writes words to imem.
// Latency: mem_we one cycle after a word's 4th byte; done/error one cycle after last byte.
// Backpressure: in_ready high for the whole image, low only once done or error.
//
// Ports: clock, reset (async, active-high), in_valid/in_byte/in_ready byte stream,
//        mem_we/mem_address/mem_write_data imem write port, cpu_hold, done, error.
module program_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    loader_state_t state, state_nxt;

    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] word_cnt;
    logic [7:0]  csum;

    logic        accept;
    logic [15:0] len_word;
    logic        shift;
    logic [31:0] word_dat;
    logic        word_vld;

    assign in_ready = (state == S_LEN0) || (state == S_LEN1) ||
                      (state == S_DATA) || (state == S_CSUM);
    assign accept   = in_valid && in_ready;
    assign len_word = {in_byte, len_lo};
    assign shift    = accept && (state == S_DATA);

    word_assembler u_word_assembler (
        .clock    (clock),
        .reset    (reset),
        .shift    (shift),
        .byte_dat (in_byte),
        .word_dat (word_dat),
        .word_vld (word_vld)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_LEN0: if (accept) state_nxt = S_LEN1;
            S_LEN1: begin
                if (accept) begin
                    if ({16'h0, len_word} > MAX_WORDS) state_nxt = S_ERROR;
                    else if (len_word == 16'h0)       state_nxt = S_CSUM;
                    else                              state_nxt = S_DATA;
                end
            end
            // len is nonzero here, so len-1 cannot underflow.
            S_DATA: if (word_vld && (word_cnt == len - 16'd1)) state_nxt = S_CSUM;
            S_CSUM: begin
                if (accept) state_nxt = (in_byte == csum) ? S_DONE : S_ERROR;
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_LEN0;
            len_lo         <= '0;
            len            <= '0;
            word_cnt       <= '0;
            csum           <= '0;
            mem_we         <= 1'b0;
            mem_address    <= BASE_ADDR;
            mem_write_data <= '0;
        end else begin
            state  <= state_nxt;
            mem_we <= word_vld;
            // Checksum covers every byte before the checksum byte itself.
            if (accept && (state != S_CSUM)) csum <= csum ^ in_byte;
            if (accept && (state == S_LEN0)) len_lo <= in_byte;
            if (accept && (state == S_LEN1)) len <= len_word;
            if (word_vld) begin
                word_cnt       <= word_cnt + 16'd1;
                mem_address    <= BASE_ADDR + {14'b0, word_cnt, 2'b00};
                mem_write_data <= word_dat;
            end
        end
    end

    assign done     = (state == S_DONE);
    assign error    = (state == S_ERROR);
    assign cpu_hold = ~done;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed and random byte streams.
// Latency: expectations derived per cycle from the stream format rules.
// Backpressure: in_valid gaps are inserted at random to exercise stalls.
module tb_program_loader;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int vectors;
    int miscompares;

    logic [7:0] stream[$];

    program_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(64)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_byte        (in_byte),
        .in_ready       (in_ready),
        .mem_we         (mem_we),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .cpu_hold       (cpu_hold),
        .done           (done),
        .error          (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic apply_reset();
        in_valid = 1'b0;
        in_byte  = 8'h00;
        reset    = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Random image of n words; optionally the checksum is made wrong.
    task automatic build_image(input int n, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        stream.delete();
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            stream.push_back(b);
        end
        x = 8'h00;
        foreach (stream[i]) x = x ^ stream[i];
        if (corrupt) x = x ^ 8'(1 + $urandom_range(254));
        stream.push_back(x);
    endtask

    // Drives the global stream and checks every cycle against a model built
    // from the format: byte index -> role, accept count -> expected status.
    task automatic run_stream(input string name, input int gap_pct, input bit do_rst);
        int n, consumed, nacc, prev, tail, k, csum_idx;
        bit len_err, good, fin;
        bit exp_we, exp_ready, exp_done, exp_err;
        logic [7:0]  x;
        logic [31:0] last_addr, last_data;

        if (do_rst) apply_reset();
        n       = int'(stream[0]) + 256 * int'(stream[1]);
        len_err = (n > 64);
        good    = 1'b0;
        if (len_err) begin
            consumed = 2;
        end else begin
            csum_idx = 2 + 4 * n;
            x = 8'h00;
            for (int i = 0; i < csum_idx; i++) x = x ^ stream[i];
            good     = (stream[csum_idx] == x);
            consumed = csum_idx + 1;
        end
        nacc      = 0;
        prev      = -1;
        tail      = 0;
        last_addr = 32'h0;
        last_data = 32'h0;
        fin       = 1'b0;

        for (int cyc = 0; cyc < 20000 && tail < 6; cyc++) begin
            @(negedge clock);
            exp_we = 1'b0;
            if (!len_err && prev >= 5 && prev < 2 + 4 * n && ((prev - 2) % 4) == 3) begin
                exp_we    = 1'b1;
                k         = (prev - 2) / 4;
                last_addr = 32'(4 * k);
                last_data = {stream[prev], stream[prev-1], stream[prev-2], stream[prev-3]};
            end
            fin       = (nacc == consumed);
            exp_ready = !fin;
            exp_done  = fin && !len_err && good;
            exp_err   = fin && !exp_done;

            vectors++;
            if ({mem_we, in_ready, done, error, cpu_hold} !==
                {exp_we, exp_ready, exp_done, exp_err, !exp_done}) begin
                miscompares++;
                $display("FAIL %s status cyc=%0d we/rdy/done/err/hold got=%b exp=%b",
                         name, cyc, {mem_we, in_ready, done, error, cpu_hold},
                         {exp_we, exp_ready, exp_done, exp_err, !exp_done});
            end
            vectors++;
            if ({mem_address, mem_write_data} !== {last_addr, last_data}) begin
                miscompares++;
                $display("FAIL %s wport cyc=%0d addr/data got=%h/%h exp=%h/%h",
                         name, cyc, mem_address, mem_write_data, last_addr, last_data);
            end
            if (fin) tail++;

            in_valid = ($urandom_range(99) >= 32'(gap_pct));
            in_byte  = (nacc < consumed) ? stream[nacc] : 8'($urandom);
            @(posedge clock);
            prev = -1;
            if (in_valid && exp_ready) begin
                prev = nacc;
                nacc++;
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (!fin) begin
            miscompares++;
            $display("FAIL %s timeout accepted=%0d exp=%0d", name, nacc, consumed);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        #1;
        vectors++;
        if ({in_ready, mem_we, mem_address, mem_write_data, cpu_hold, done, error} !==
            {1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values got rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b exp 1 0 0 0 1 0 0",
                     in_ready, mem_we, mem_address, mem_write_data, cpu_hold, done, error);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({in_ready, mem_we, cpu_hold, done, error} !== 5'b10100) begin
            miscompares++;
            $display("FAIL idle_stall got=%b exp=10100",
                     {in_ready, mem_we, cpu_hold, done, error});
        end
    endtask

    task automatic test_one_word();
        stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h02};
        run_stream("one_word", 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                   8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h81};
        run_stream("two_word", 0, 1'b1);
    endtask

    task automatic test_bad_csum();
        stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h03};
        run_stream("bad_csum", 0, 1'b1);
    endtask

    task automatic test_oversize();
        stream = '{8'h41, 8'h00};
        run_stream("oversize", 0, 1'b1);
    endtask

    task automatic test_gaps();
        stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                   8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h81};
        run_stream("gaps", 40, 1'b1);
    endtask

    task automatic test_empty_and_max();
        stream = '{8'h00, 8'h00, 8'h00};
        run_stream("empty", 0, 1'b1);
        build_image(64, 1'b0);
        run_stream("max_words", 10, 1'b1);
        stream = '{8'h00, 8'h01};
        run_stream("len_256", 0, 1'b1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            build_image(int'($urandom_range(1, 10)), ($urandom_range(2) == 0));
            run_stream("random", int'($urandom_range(50)), 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h02};
        // Two length bytes and all four payload bytes at full rate.
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_byte  = stream[i];
            @(posedge clock);
        end
        #1;
        in_valid = 1'b0;
        vectors++;
        if (mem_we !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_we got=%b exp=1", mem_we);
        end
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if ({in_ready, mem_we, mem_address, mem_write_data, cpu_hold, done, error} !==
            {1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset got rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b exp 1 0 0 0 1 0 0",
                     in_ready, mem_we, mem_address, mem_write_data, cpu_hold, done, error);
        end
        @(posedge clock);
        #1;
        vectors++;
        if (mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL trailing_we got=%b exp=0", mem_we);
        end
        @(negedge clock);
        reset = 1'b0;
        run_stream("after_reset", 0, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_one_word();
        test_back_to_back();
        test_bad_csum();
        test_oversize();
        test_gaps();
        test_empty_and_max();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
